// File: rtl/alu_pkg.sv
// Shared types and helpers for the digit-serial RV32I ALU.
package alu_pkg;

  // Operation codes are {func7[5], func3}.
  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b1000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b1101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111
  } alu_op_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPUTE = 1'b1
  } alu_state_t;

  // Number of DW-bit digits in an XLEN-bit word.
  function automatic int unsigned digits(int unsigned xlen, int unsigned dw);
    return xlen / dw;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DW-bit ripple-carry adder built from full-adder cells.
module digit_adder #(
  parameter int unsigned DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] s,
  output logic          cout
);

  logic [DW:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DW; i++) begin : g_fa
    // One full-adder cell per bit; carry ripples LSB to MSB.
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[DW];

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial RV32I integer ALU: DW bits per clock, start/busy/done handshake.
module digit_serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned DW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rd
);

  localparam int unsigned ND  = digits(XLEN, DW);
  localparam int unsigned CW  = $clog2(ND + 1);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned SW  = SHW + 1;
  localparam int unsigned DSH = $clog2(DW);
  localparam logic [DW-1:0] SIGN_MASK = DW'(1) << (DW - 1);

  if (XLEN % DW != 0) begin : g_chk_div
    $error("DW must divide XLEN");
  end
  if ((DW & (DW - 1)) != 0) begin : g_chk_pow2
    $error("DW must be a power of 2");
  end

  alu_state_t      state_q, state_d;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic            carry_q, lt_q;
  logic [SW-1:0]   rem_q;
  logic [CW-1:0]   cnt_q, n_q;

  logic            accept, last;
  logic [SW-1:0]   shamt_in, amt;
  logic [CW-1:0]   n_d;
  logic [DW-1:0]   b_dig, sum_dig, logic_dig, res_dig, a_cmp, b_cmp;
  logic            sum_cout, lt_d;
  logic [XLEN-1:0] res_d, a_next, rd_d;

  digit_adder #(.DW(DW)) u_adder (
    .a    (a_q[DW-1:0]),
    .b    (b_dig),
    .cin  (carry_q),
    .s    (sum_dig),
    .cout (sum_cout)
  );

  // Handshake decode: accept only when idle; last marks edge EN.
  always_comb begin
    accept = start && (state_q == IDLE);
    last   = (state_q == COMPUTE) && ((cnt_q + CW'(1)) == n_q);
    busy   = (state_q == COMPUTE);
  end

  // Per-op cycle count, fixed at accept from the incoming op and shamt.
  always_comb begin
    shamt_in = {1'b0, rs2[SHW-1:0]};
    n_d      = CW'(1);
    case (op)
      OP_SLL, OP_SRL, OP_SRA:
        n_d = (shamt_in == '0) ? CW'(1) : CW'((shamt_in + SW'(DW - 1)) >> DSH);
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND:
        n_d = CW'(ND);
      default:
        n_d = CW'(1);
    endcase
  end

  // Next-state logic for the IDLE/COMPUTE sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COMPUTE;
      COMPUTE: if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Digit datapath: adder, logic, compare and variable-step shifter.
  always_comb begin
    b_dig = (op_q == OP_SUB) ? ~b_q[DW-1:0] : b_q[DW-1:0];

    logic_dig = a_q[DW-1:0] & b_q[DW-1:0];
    case (op_q)
      OP_XOR:  logic_dig = a_q[DW-1:0] ^ b_q[DW-1:0];
      OP_OR:   logic_dig = a_q[DW-1:0] | b_q[DW-1:0];
      default: logic_dig = a_q[DW-1:0] & b_q[DW-1:0];
    endcase

    // Flipping both sign bits turns the signed compare into an unsigned one.
    a_cmp = a_q[DW-1:0] ^ (((op_q == OP_SLT) && last) ? SIGN_MASK : '0);
    b_cmp = b_q[DW-1:0] ^ (((op_q == OP_SLT) && last) ? SIGN_MASK : '0);
    if (a_cmp < b_cmp)      lt_d = 1'b1;
    else if (a_cmp > b_cmp) lt_d = 1'b0;
    else                    lt_d = lt_q;

    res_dig = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? sum_dig : logic_dig;
    res_d   = (res_q >> DW) | (XLEN'(res_dig) << (XLEN - DW));

    amt = (rem_q > SW'(DW)) ? SW'(DW) : rem_q;
    case (op_q)
      OP_SLL:  a_next = a_q << amt;
      OP_SRL:  a_next = a_q >> amt;
      OP_SRA:  a_next = $signed(a_q) >>> amt;
      default: a_next = a_q >> DW;
    endcase

    case (op_q)
      OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND: rd_d = res_d;
      OP_SLT, OP_SLTU:                       rd_d = XLEN'(lt_d);
      OP_SLL, OP_SRL, OP_SRA:                rd_d = a_next;
      default:                               rd_d = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand latching, per-digit working registers and result/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      lt_q    <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      done    <= 1'b0;
      rd      <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q    <= op;
        a_q     <= rs1;
        b_q     <= rs2;
        res_q   <= '0;
        carry_q <= (op == OP_SUB);
        lt_q    <= 1'b0;
        rem_q   <= shamt_in;
        cnt_q   <= '0;
        n_q     <= n_d;
      end else if (state_q == COMPUTE) begin
        a_q     <= a_next;
        b_q     <= b_q >> DW;
        res_q   <= res_d;
        carry_q <= sum_cout;
        lt_q    <= lt_d;
        rem_q   <= rem_q - amt;
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          rd   <= rd_d;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_alu.sv
// Self-checking bench for digit_serial_alu against a word-level reference model.
module tb_digit_serial_alu;

  parameter int unsigned DW = 4;
  localparam int unsigned XLEN = 32;
  localparam int unsigned ND = XLEN / DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        busy, done;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  digit_serial_alu #(.XLEN(XLEN), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .rd(rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_rd(logic [3:0] o, logic [31:0] a, logic [31:0] b);
    int unsigned sh = b[4:0];
    case (o)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return $signed(a) >>> sh;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(logic [3:0] o, logic [31:0] b);
    int unsigned sh = b[4:0];
    case (o)
      4'b0001, 4'b0101, 4'b1101: return (sh == 0) ? 1 : int'((sh + DW - 1) / DW);
      4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111: return int'(ND);
      default: return 1;
    endcase
  endfunction

  // Issues one op from idle and waits (bounded) for its done pulse.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat, output int bcnt, output bit tmo);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 4'($urandom);
    bcnt = busy ? 1 : 0; lat = 0; tmo = 1'b1; r = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; tmo = 1'b0; r = rd; break; end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_rd got=%h exp=0", rd); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [3:0]  d_op  [9] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b1101, 4'b0101, 4'b0001};
    logic [31:0] d_a   [9] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678,
                               32'h80000000, 32'h80000000, 32'h1};
    logic [31:0] d_b   [9] = '{32'h1, 32'd7, 32'h1, 32'h1, 32'h12345678, 32'h12345678, 32'd31, 32'd31, 32'd0};
    logic [31:0] d_exp [9] = '{32'h0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h1};
    int          d_lat [9];
    logic [31:0] r;
    int lat, bcnt;
    bit tmo;
    for (int k = 0; k < 6; k++) d_lat[k] = int'(ND);
    d_lat[6] = int'((31 + DW - 1) / DW);
    d_lat[7] = d_lat[6];
    d_lat[8] = 1;
    for (int k = 0; k < 9; k++) begin
      run_op(d_op[k], d_a[k], d_b[k], r, lat, bcnt, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL dir%0d_timeout no done", k); end
      checks++; if (r !== d_exp[k]) begin errors++; $display("FAIL dir%0d_rd got=%h exp=%h", k, r, d_exp[k]); end
      checks++; if (lat !== d_lat[k]) begin errors++; $display("FAIL dir%0d_lat got=%0d exp=%0d", k, lat, d_lat[k]); end
      checks++; if (bcnt !== d_lat[k]) begin errors++; $display("FAIL dir%0d_busy got=%0d exp=%0d", k, bcnt, d_lat[k]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_done got=%b exp=0", k, busy); end
    end
  endtask

  task automatic test_random;
    logic [3:0]  o;
    logic [31:0] a, b, r;
    int lat, bcnt;
    bit tmo;
    for (int k = 0; k < 80; k++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (k % 4 == 0) b = a;
      run_op(o, a, b, r, lat, bcnt, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL rnd%0d_timeout op=%b", k, o); end
      checks++; if (r !== ref_rd(o, a, b))
        begin errors++; $display("FAIL rnd%0d_rd op=%b a=%h b=%h got=%h exp=%h", k, o, a, b, r, ref_rd(o, a, b)); end
      checks++; if (lat !== ref_lat(o, b))
        begin errors++; $display("FAIL rnd%0d_lat op=%b got=%0d exp=%0d", k, o, lat, ref_lat(o, b)); end
    end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] a = 32'h0000_1234, b = 32'h0000_0FF0, got = '0;
    int dones = 0;
    op = 4'b1000; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < int'(ND) + 10; i++) begin
      if (busy) begin start = 1'b1; op = 4'b0000; rs1 = $urandom; rs2 = $urandom; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin dones++; got = rd; end
    end
    start = 1'b0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++; if (got !== a - b) begin errors++; $display("FAIL ignore_rd got=%h exp=%h", got, a - b); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1 = $urandom, b1 = $urandom, a2 = $urandom, b2 = 32'd13;
    logic [31:0] r;
    int lat, bcnt;
    bit tmo;
    run_op(4'b0111, a1, b1, r, lat, bcnt, tmo);
    checks++; if (r !== (a1 & b1)) begin errors++; $display("FAIL b2b_first_rd got=%h exp=%h", r, a1 & b1); end
    op = 4'b1101; rs1 = a2; rs2 = b2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got=%b exp=1", busy); end
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; r = rd; break; end
    end
    checks++; if (lat !== ref_lat(4'b1101, b2)) begin errors++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, ref_lat(4'b1101, b2)); end
    checks++; if (r !== ref_rd(4'b1101, a2, b2)) begin errors++; $display("FAIL b2b_rd got=%h exp=%h", r, ref_rd(4'b1101, a2, b2)); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a = $urandom, b = $urandom, r;
    int lat, bcnt, late = 0;
    bit tmo;
    run_op(4'b0110, 32'hA5A5_0000, 32'h0000_5A5A, r, lat, bcnt, tmo);
    op = 4'b0000; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL midrst_rd got=%h exp=0", rd); end
    for (int i = 0; i < int'(ND) + 5; i++) begin
      @(posedge clk); #1;
      if (done) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL midrst_late_done got=%0d exp=0", late); end
    run_op(4'b0000, a, b, r, lat, bcnt, tmo);
    checks++; if (r !== a + b) begin errors++; $display("FAIL midrst_next_rd got=%h exp=%h", r, a + b); end
    checks++; if (lat !== int'(ND)) begin errors++; $display("FAIL midrst_next_lat got=%0d exp=%0d", lat, ND); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
